// File: rtl/sistema_pkg.sv
// Shared types and default constants for the maintenance scheduler.
package sistema_pkg;

  typedef enum logic [1:0] {
    ESPERANDO     = 2'd0,
    MANTENIMIENTO = 2'd1,
    ERROR         = 2'd2
  } estado_t;

  localparam logic [7:0] CODIGO_ERROR = 8'hFF;

  localparam int N_ESTACIONES_DEF  = 4;
  localparam int TIEMPO_MAXIMO_DEF = 200;
  localparam int DURACION_MANT_DEF = 8;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: the first requester after the last-served
// station (wrapping) wins.
module arbitro_rr #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     solicitud_i,
  input  logic [IDX_W-1:0] ultimo_i,
  output logic             valido_o,
  output logic [N-1:0]     concesion_o,
  output logic [IDX_W-1:0] indice_o
);

  // Scan from ultimo+1 upward; only the first set bit may claim the index.
  always_comb begin
    int cand;
    cand     = 0;
    valido_o = 1'b0;
    indice_o = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ultimo_i) + k) % N;
      indice_o = (!valido_o && solicitud_i[cand]) ? IDX_W'(cand) : indice_o;
      valido_o = valido_o | solicitud_i[cand];
    end
    concesion_o = valido_o ? ({{(N-1){1'b0}}, 1'b1} << indice_o) : '0;
  end

endmodule

// File: rtl/planificador_mantenimiento.sv
// Round-robin maintenance scheduler: fixed-length grants, per-station and total
// counters, and an idle watchdog that latches an error until cleared.
module planificador_mantenimiento
  import sistema_pkg::*;
#(
  parameter int N_ESTACIONES  = N_ESTACIONES_DEF,
  parameter int TIEMPO_MAXIMO = TIEMPO_MAXIMO_DEF,
  parameter int DURACION_MANT = DURACION_MANT_DEF
) (
  input  logic                            reloj,
  input  logic                            reset,
  input  logic [N_ESTACIONES-1:0]         solicitud,
  input  logic                            borrar_error,
  output logic [N_ESTACIONES-1:0]         concesion,
  output logic [$clog2(N_ESTACIONES)-1:0] estacion_activa,
  output logic                            ocupado,
  output logic                            error_flag,
  output logic [1:0]                      estado,
  output logic [7:0]                      estado_registro,
  output logic [7:0]                      total_mant
);

  localparam int               IDX_W      = $clog2(N_ESTACIONES);
  localparam logic [7:0]       TMAX       = 8'(TIEMPO_MAXIMO);
  localparam logic [7:0]       SERV_INI   = 8'(DURACION_MANT - 1);
  localparam logic [IDX_W-1:0] ULTIMO_INI = IDX_W'(N_ESTACIONES - 1);

  estado_t                 estado_q, estado_d;
  logic [7:0]              tiempo_q, tiempo_d;
  logic [7:0]              servicio_q, servicio_d;
  logic [7:0]              cuenta_q [N_ESTACIONES];
  logic [7:0]              cuenta_d [N_ESTACIONES];
  logic [IDX_W-1:0]        ultimo_q, ultimo_d;
  logic [IDX_W-1:0]        activa_q, activa_d;
  logic [N_ESTACIONES-1:0] concesion_q, concesion_d;
  logic                    ocupado_q, ocupado_d;
  logic                    error_q, error_d;
  logic [7:0]              registro_q, registro_d;
  logic [7:0]              total_q, total_d;

  logic                    arb_valido_s;
  logic [N_ESTACIONES-1:0] arb_concesion_s;
  logic [IDX_W-1:0]        arb_indice_s;

  arbitro_rr #(
    .N     (N_ESTACIONES),
    .IDX_W (IDX_W)
  ) u_arbitro (
    .solicitud_i (solicitud),
    .ultimo_i    (ultimo_q),
    .valido_o    (arb_valido_s),
    .concesion_o (arb_concesion_s),
    .indice_o    (arb_indice_s)
  );

  // State and output registers; reset puts the pointer on the last station so 0 wins first.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      estado_q    <= ESPERANDO;
      tiempo_q    <= 8'd0;
      servicio_q  <= 8'd0;
      for (int i = 0; i < N_ESTACIONES; i++) begin
        cuenta_q[i] <= 8'd0;
      end
      ultimo_q    <= ULTIMO_INI;
      activa_q    <= '0;
      concesion_q <= '0;
      ocupado_q   <= 1'b0;
      error_q     <= 1'b0;
      registro_q  <= 8'd0;
      total_q     <= 8'd0;
    end else begin
      estado_q    <= estado_d;
      tiempo_q    <= tiempo_d;
      servicio_q  <= servicio_d;
      cuenta_q    <= cuenta_d;
      ultimo_q    <= ultimo_d;
      activa_q    <= activa_d;
      concesion_q <= concesion_d;
      ocupado_q   <= ocupado_d;
      error_q     <= error_d;
      registro_q  <= registro_d;
      total_q     <= total_d;
    end
  end

  // Next-state and next-output logic; a pending request beats the watchdog limit.
  always_comb begin
    estado_d    = estado_q;
    tiempo_d    = tiempo_q;
    servicio_d  = servicio_q;
    cuenta_d    = cuenta_q;
    ultimo_d    = ultimo_q;
    activa_d    = activa_q;
    concesion_d = concesion_q;
    ocupado_d   = ocupado_q;
    error_d     = error_q;
    registro_d  = registro_q;
    total_d     = total_q;
    case (estado_q)
      ESPERANDO: begin
        if (arb_valido_s) begin
          estado_d    = MANTENIMIENTO;
          concesion_d = arb_concesion_s;
          activa_d    = arb_indice_s;
          servicio_d  = SERV_INI;
          tiempo_d    = 8'd0;
          ocupado_d   = 1'b1;
        end else if (tiempo_q == TMAX) begin
          estado_d    = ERROR;
          concesion_d = '0;
          error_d     = 1'b1;
          registro_d  = CODIGO_ERROR;
        end else begin
          tiempo_d = tiempo_q + 8'd1;
        end
      end
      MANTENIMIENTO: begin
        if (servicio_q == 8'd0) begin
          cuenta_d[activa_q] = cuenta_q[activa_q] + 8'd1;
          registro_d         = cuenta_q[activa_q] + 8'd1;
          total_d            = total_q + 8'd1;
          ultimo_d           = activa_q;
          estado_d           = ESPERANDO;
          concesion_d        = '0;
          ocupado_d          = 1'b0;
        end else begin
          servicio_d = servicio_q - 8'd1;
        end
      end
      ERROR: begin
        if (borrar_error) begin
          estado_d   = ESPERANDO;
          tiempo_d   = 8'd0;
          registro_d = 8'd0;
          error_d    = 1'b0;
        end else begin
          estado_d = ERROR;
        end
      end
      default: begin
        estado_d    = ESPERANDO;
        tiempo_d    = 8'd0;
        concesion_d = '0;
        ocupado_d   = 1'b0;
        error_d     = 1'b0;
      end
    endcase
  end

  assign concesion       = concesion_q;
  assign estacion_activa = activa_q;
  assign ocupado         = ocupado_q;
  assign error_flag      = error_q;
  assign estado          = estado_q;
  assign estado_registro = registro_q;
  assign total_mant      = total_q;

endmodule

// File: tb/tb_planificador_mantenimiento.sv
// Self-checking bench for planificador_mantenimiento: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_planificador_mantenimiento;

  localparam int N  = 4;
  localparam int TM = 200;
  localparam int D  = 8;

  logic       reloj = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] solicitud = 4'd0;
  logic       borrar_error = 1'b0;
  logic [3:0] concesion;
  logic [1:0] estacion_activa;
  logic       ocupado;
  logic       error_flag;
  logic [1:0] estado;
  logic [7:0] estado_registro;
  logic [7:0] total_mant;

  int errors = 0;
  int checks = 0;

  planificador_mantenimiento #(
    .N_ESTACIONES  (N),
    .TIEMPO_MAXIMO (TM),
    .DURACION_MANT (D)
  ) dut (
    .reloj           (reloj),
    .reset           (reset),
    .solicitud       (solicitud),
    .borrar_error    (borrar_error),
    .concesion       (concesion),
    .estacion_activa (estacion_activa),
    .ocupado         (ocupado),
    .error_flag      (error_flag),
    .estado          (estado),
    .estado_registro (estado_registro),
    .total_mant      (total_mant)
  );

  always #5 reloj = ~reloj;

  // Behavioural model: mode 0 idle, 1 serving, 2 error; grant cycles left counted down.
  int m_modo, m_inactivo, m_resta, m_quien, m_ultimo, m_total, m_reg;
  int m_cuentas [N];

  task automatic modelo_reset();
    m_modo = 0; m_inactivo = 0; m_resta = 0; m_quien = 0;
    m_ultimo = N - 1; m_total = 0; m_reg = 0;
    for (int i = 0; i < N; i++) m_cuentas[i] = 0;
  endtask

  task automatic modelo_flanco(input logic [3:0] s, input logic b);
    bit hallado;
    hallado = 1'b0;
    if (m_modo == 0) begin
      if (s != 4'd0) begin
        for (int k = 1; k <= N; k++) begin
          if (!hallado && s[(m_ultimo + k) % N]) begin
            m_quien = (m_ultimo + k) % N;
            hallado = 1'b1;
          end
        end
        m_modo = 1; m_resta = D; m_inactivo = 0;
      end else if (m_inactivo == TM) begin
        m_modo = 2;
      end else begin
        m_inactivo = m_inactivo + 1;
      end
    end else if (m_modo == 1) begin
      m_resta = m_resta - 1;
      if (m_resta == 0) begin
        m_cuentas[m_quien] = (m_cuentas[m_quien] + 1) % 256;
        m_reg = m_cuentas[m_quien];
        m_total = (m_total + 1) % 256;
        m_ultimo = m_quien;
        m_modo = 0;
      end
    end else begin
      if (b) begin
        m_modo = 0; m_inactivo = 0; m_reg = 0;
      end
    end
  endtask

  function automatic logic [31:0] empaquetar(input logic [3:0] c, input logic o, input logic e,
                                             input logic [1:0] s, input logic [7:0] r,
                                             input logic [7:0] t, input logic [1:0] a);
    return {6'd0, c, o, e, s, r, t, a};
  endfunction

  function automatic logic [31:0] observado();
    return {6'd0, concesion, ocupado, error_flag, estado, estado_registro, total_mant, estacion_activa};
  endfunction

  function automatic logic [31:0] esperado_modelo();
    logic [3:0] c;
    logic [7:0] r;
    c = (m_modo == 1) ? (4'd1 << m_quien) : 4'd0;
    r = (m_modo == 2) ? 8'hFF : 8'(m_reg);
    return empaquetar(c, m_modo == 1, m_modo == 2, 2'(m_modo), r, 8'(m_total), 2'(m_quien));
  endfunction

  task automatic comparar(input string nombre, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nombre, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge reloj);
    #1;
  endtask

  task automatic aplicar_reset();
    solicitud = 4'd0;
    borrar_error = 1'b0;
    reset = 1'b1;
    #1;
    comparar("reset_salidas", observado(), 32'd0);
    repeat (2) @(posedge reloj);
    @(negedge reloj);
    reset = 1'b0;
    modelo_reset();
  endtask

  typedef struct {
    logic [3:0]  sol;
    logic        bor;
    int          ciclos;
    logic [31:0] esp;
    string       nombre;
  } vector_t;

  vector_t tabla [9];
  int len, n;

  initial begin
    tabla[0] = '{4'h0, 1'b0, 3, empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 2'd0), "inactivo"};
    tabla[1] = '{4'h4, 1'b0, 1, empaquetar(4'h4, 1'b1, 1'b0, 2'd1, 8'd0, 8'd0, 2'd2), "concede_2"};
    tabla[2] = '{4'h0, 1'b0, 7, empaquetar(4'h4, 1'b1, 1'b0, 2'd1, 8'd0, 8'd0, 2'd2), "mantiene_2"};
    tabla[3] = '{4'h0, 1'b0, 1, empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd1, 8'd1, 2'd2), "fin_2"};
    tabla[4] = '{4'hF, 1'b0, 1, empaquetar(4'h8, 1'b1, 1'b0, 2'd1, 8'd1, 8'd1, 2'd3), "concede_3"};
    tabla[5] = '{4'hF, 1'b0, 8, empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd1, 8'd2, 2'd3), "fin_3"};
    tabla[6] = '{4'hF, 1'b0, 1, empaquetar(4'h1, 1'b1, 1'b0, 2'd1, 8'd1, 8'd2, 2'd0), "concede_0"};
    tabla[7] = '{4'h0, 1'b0, 8, empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd1, 8'd3, 2'd0), "fin_0"};
    tabla[8] = '{4'h0, 1'b1, 1, empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd1, 8'd3, 2'd0), "borrar_inerte"};

    #2;
    aplicar_reset();
    for (int v = 0; v < 9; v++) begin
      solicitud = tabla[v].sol;
      borrar_error = tabla[v].bor;
      repeat (tabla[v].ciclos) ciclo();
      comparar(tabla[v].nombre, observado(), tabla[v].esp);
    end
    borrar_error = 1'b0;

    // Fairness with all stations requesting.
    aplicar_reset();
    solicitud = 4'hF;
    for (int g = 0; g < 5; g++) begin
      ciclo();
      comparar("rr_orden", 32'(concesion), 32'(4'd1 << (g % 4)));
      len = 1;
      for (int c = 0; c < 20; c++) begin
        ciclo();
        if (concesion !== (4'd1 << (g % 4))) break;
        len++;
      end
      comparar("rr_longitud", 32'(len), 32'(D));
      comparar("rr_cuenta", 32'(estado_registro), (g < 4) ? 32'd1 : 32'd2);
    end

    // Withdrawal mid-service, then asynchronous reset mid-grant.
    aplicar_reset();
    solicitud = 4'h2;
    ciclo();
    comparar("retiro_concede", 32'(concesion), 32'h2);
    ciclo();
    solicitud = 4'h0;
    len = 2;
    for (int c = 0; c < 20; c++) begin
      ciclo();
      if (concesion !== 4'h2) break;
      len++;
    end
    comparar("retiro_longitud", 32'(len), 32'(D));
    comparar("retiro_cuenta", {16'd0, estado_registro, total_mant}, 32'h0101);
    solicitud = 4'hF;
    ciclo();
    comparar("pre_reset_concede", 32'(concesion), 32'h4);
    ciclo();
    #2;
    aplicar_reset();
    solicitud = 4'hF;
    ciclo();
    comparar("post_reset_estacion0", observado(),
             empaquetar(4'h1, 1'b1, 1'b0, 2'd1, 8'd0, 8'd0, 2'd0));

    // Watchdog, ignored requests in ERROR, and clearing.
    aplicar_reset();
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      ciclo();
      if (error_flag) begin
        n = i;
        break;
      end
    end
    comparar("watchdog_flanco", 32'(n), 32'(TM + 1));
    comparar("watchdog_salidas", observado(),
             empaquetar(4'h0, 1'b0, 1'b1, 2'd2, 8'hFF, 8'd0, 2'd0));
    solicitud = 4'hF;
    repeat (5) ciclo();
    comparar("error_ignora", observado(),
             empaquetar(4'h0, 1'b0, 1'b1, 2'd2, 8'hFF, 8'd0, 2'd0));
    solicitud = 4'h0;
    borrar_error = 1'b1;
    ciclo();
    borrar_error = 1'b0;
    comparar("borrar_error", observado(),
             empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 2'd0));

    // Request arriving exactly when the idle count sits at the limit.
    aplicar_reset();
    repeat (TM) ciclo();
    solicitud = 4'h1;
    ciclo();
    comparar("empate_limite", observado(),
             empaquetar(4'h1, 1'b1, 1'b0, 2'd1, 8'd0, 8'd0, 2'd0));

    // 8-bit wrap of station and total counters.
    aplicar_reset();
    solicitud = 4'h1;
    repeat (255 * (D + 1)) ciclo();
    comparar("cuenta_255", observado(),
             empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd255, 8'd255, 2'd0));
    repeat (D + 1) ciclo();
    comparar("cuenta_envuelve", observado(),
             empaquetar(4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 2'd0));

    // Random traffic: dense requests, then sparse ones so the watchdog fires.
    aplicar_reset();
    for (int i = 0; i < 1500; i++) begin
      solicitud = 4'($urandom);
      borrar_error = ($urandom_range(0, 7) == 0);
      modelo_flanco(solicitud, borrar_error);
      ciclo();
      comparar("aleatorio_denso", observado(), esperado_modelo());
    end
    for (int i = 0; i < 1500; i++) begin
      solicitud = ($urandom_range(0, 149) == 0) ? 4'($urandom) : 4'h0;
      borrar_error = ($urandom_range(0, 39) == 0);
      modelo_flanco(solicitud, borrar_error);
      ciclo();
      comparar("aleatorio_disperso", observado(), esperado_modelo());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
